grf_wb_arbiter: RTL and testbench

Shares the single GRF write port between two writeback sources.
- Main pipeline WB stage: highest priority, no buffering.
- Multi-cycle unit (MDU/coprocessor) results: queued in a small FIFO and drained into idle write slots.
- Starvation guard forces a pipeline stall slot when the FIFO head waits too long.
- Exports a pending-register mask so hazard logic can stall readers of not-yet-written registers.

---
 rtl/grf_wb_arbiter.sv | 104 ++++++++++
 tb/tb_grf_wb_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter: shares the GRF write port between the pipeline WB stage and a queued MDU result stream.
// Define GRFARB_TRACE_EN to print every GRF write and every forced stall slot.
module grf_wb_arbiter #(
  parameter int DEPTH    = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_valid,
  input  logic [4:0]  p_a3,
  input  logic [31:0] p_wd,
  input  logic [31:0] p_pc,
  input  logic        m_valid,
  output logic        m_ready,
  input  logic [4:0]  m_a3,
  input  logic [31:0] m_wd,
  input  logic [31:0] m_pc,
  output logic        p_stall,
  output logic        wr,
  output logic [4:0]  a3,
  output logic [31:0] wd,
  output logic [31:0] pc,
  output logic [31:0] busy_mask
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WMAX = CW'(MAX_WAIT);
  logic [4:0]       q_a3 [DEPTH];
  logic [31:0]      q_wd [DEPTH];
  logic [31:0]      q_pc [DEPTH];
  logic [DEPTH-1:0] vld, vld_nxt;
  logic [AW-1:0]    wp, rp;
  logic [CW-1:0]    wait_cnt, wait_nxt;
  logic             full, empty, push, grant_p, pop, stall_nxt;
  // Occupancy is tracked per slot: the slot under the write pointer being valid means full.
  assign full    = vld[wp];
  assign empty   = !vld[rp];
  assign m_ready = !full;
  // Zero-destination MDU results complete the handshake but are never stored.
  assign push    = m_valid && !full && |m_a3;
  // A pipeline request during a stall slot is ignored so the starving head gets through.
  assign grant_p = p_valid && !p_stall;
  assign pop     = !grant_p && !empty;
  // Slot valid bits, wait counter and stall request for the next edge.
  always_comb begin
    vld_nxt   = (vld & ~(DEPTH'(pop) << rp)) | (DEPTH'(push) << wp);
    wait_nxt  = (pop || empty) ? '0 : (wait_cnt == WMAX ? wait_cnt : wait_cnt + 1'b1);
    stall_nxt = (wait_cnt == WMAX) && !p_stall;
  end
  // Queue control state; reset drops every queued result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld      <= '0;
      wp       <= '0;
      rp       <= '0;
      wait_cnt <= '0;
    end else begin
      vld      <= vld_nxt;
      wp       <= wp + AW'(push);
      rp       <= rp + AW'(pop);
      wait_cnt <= wait_nxt;
    end
  end
  // Queue payload storage; validity lives in vld so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      q_a3[wp] <= m_a3;
      q_wd[wp] <= m_wd;
      q_pc[wp] <= m_pc;
    end
  end
  // Registered GRF write port and stall slot; address/data/pc hold when nothing is granted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr      <= 1'b0;
      a3      <= '0;
      wd      <= '0;
      pc      <= '0;
      p_stall <= 1'b0;
    end else begin
      wr      <= grant_p ? |p_a3 : pop;
      p_stall <= stall_nxt;
      if (grant_p || pop) begin
        a3 <= grant_p ? p_a3 : q_a3[rp];
        wd <= grant_p ? p_wd : q_wd[rp];
        pc <= grant_p ? p_pc : q_pc[rp];
      end
    end
  end
  // Registers still owed a write by a queued MDU result; r0 is never reported.
  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++) busy_mask = busy_mask | (32'(vld[i]) << q_a3[i]);
    busy_mask[0] = 1'b0;
  end
`ifdef GRFARB_TRACE_EN
  // Trace of each GRF write as it is loaded and of each forced stall slot.
  always_ff @(posedge clk) begin
    if (reset && grant_p && |p_a3) $display("%0t P pc=%h a3=%0d wd=%h", $time, p_pc, p_a3, p_wd);
    else if (reset && pop) $display("%0t M pc=%h a3=%0d wd=%h", $time, q_pc[rp], q_a3[rp], q_wd[rp]);
    if (reset && stall_nxt) $display("%0t STALL", $time);
  end
`endif
endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb_grf_wb_arbiter: vector table, corner sequences and randomized run against a queue-based model.
module tb_grf_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int MAXW  = 8;
  logic        clk = 1'b0, reset = 1'b0;
  logic        p_valid = 1'b0, m_valid = 1'b0;
  logic [4:0]  p_a3 = '0, m_a3 = '0;
  logic [31:0] p_wd = '0, p_pc = '0, m_wd = '0, m_pc = '0;
  logic        m_ready, p_stall, wr;
  logic [4:0]  a3;
  logic [31:0] wd, pc, busy_mask;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  grf_wb_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .reset(reset), .p_valid(p_valid), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc),
    .m_valid(m_valid), .m_ready(m_ready), .m_a3(m_a3), .m_wd(m_wd), .m_pc(m_pc),
    .p_stall(p_stall), .wr(wr), .a3(a3), .wd(wd), .pc(pc), .busy_mask(busy_mask)
  );
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input logic pv, input logic [4:0] pa, input logic [31:0] pw,
                       input logic mv, input logic [4:0] ma, input logic [31:0] mw);
    p_valid = pv; p_a3 = pa; p_wd = pw; p_pc = 32'h400;
    m_valid = mv; m_a3 = ma; m_wd = mw; m_pc = 32'h800;
  endtask
  typedef struct {
    logic pv; logic [4:0] pa; logic [31:0] pw;
    logic mv; logic [4:0] ma; logic [31:0] mw;
    logic ewr; logic [4:0] ea; logic [31:0] ew; logic [31:0] eb;
  } vec_t;
  vec_t tbl [12];
  typedef struct {logic [4:0] a3; logic [31:0] wd; logic [31:0] pc;} ent_t;
  ent_t        mq[$];
  int          mwait;
  bit          mstall, ewr;
  logic [4:0]  ea3;
  logic [31:0] ewd, epc;
  function automatic logic [31:0] mbusy();
    logic [31:0] b = '0;
    foreach (mq[i]) b[mq[i].a3] = 1'b1;
    return b;
  endfunction
  task automatic model_step();
    bit gp, pp, sn;
    int n = mq.size();
    gp = p_valid && !mstall;
    pp = !gp && n > 0;
    if (gp) begin ewr = (p_a3 != 0); ea3 = p_a3; ewd = p_wd; epc = p_pc; end
    else if (pp) begin ewr = 1'b1; ea3 = mq[0].a3; ewd = mq[0].wd; epc = mq[0].pc; end
    else ewr = 1'b0;
    sn = (mwait == MAXW) && !mstall;
    mwait = (pp || n == 0) ? 0 : (mwait < MAXW ? mwait + 1 : MAXW);
    mstall = sn;
    if (pp) void'(mq.pop_front());
    if (m_valid && n < DEPTH && m_a3 != 0) mq.push_back('{m_a3, m_wd, m_pc});
  endtask
  initial begin
    tbl[0]  = '{1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'h0,    1'b1, 5'd5, 32'h1234, 32'h0};
    tbl[1]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hCAFE, 1'b0, 5'd5, 32'h1234, 32'h200};
    tbl[2]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd9, 32'hCAFE, 32'h0};
    tbl[3]  = '{1'b0, 5'd0, 32'h0,    1'b1, 5'd0, 32'hDEAD, 1'b0, 5'd9, 32'hCAFE, 32'h0};
    tbl[4]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd9, 32'hCAFE, 32'h0};
    tbl[5]  = '{1'b1, 5'd1, 32'h11,   1'b1, 5'd3, 32'hA,    1'b1, 5'd1, 32'h11,   32'h8};
    tbl[6]  = '{1'b1, 5'd2, 32'h22,   1'b1, 5'd3, 32'hB,    1'b1, 5'd2, 32'h22,   32'h8};
    tbl[7]  = '{1'b1, 5'd4, 32'h44,   1'b1, 5'd7, 32'hC,    1'b1, 5'd4, 32'h44,   32'h88};
    tbl[8]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hA,    32'h88};
    tbl[9]  = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd3, 32'hB,    32'h80};
    tbl[10] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b1, 5'd7, 32'hC,    32'h0};
    tbl[11] = '{1'b0, 5'd0, 32'h0,    1'b0, 5'd0, 32'h0,    1'b0, 5'd7, 32'hC,    32'h0};
    #1;
    chk("rst_wr", 32'(wr), 32'h0);
    chk("rst_a3", 32'(a3), 32'h0);
    chk("rst_wd", wd, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_stall", 32'(p_stall), 32'h0);
    chk("rst_busy", busy_mask, 32'h0);
    chk("rst_ready", 32'(m_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].pv, tbl[i].pa, tbl[i].pw, tbl[i].mv, tbl[i].ma, tbl[i].mw);
      @(negedge clk);
      chk($sformatf("tbl%0d_wr", i), 32'(wr), 32'(tbl[i].ewr));
      chk($sformatf("tbl%0d_a3", i), 32'(a3), 32'(tbl[i].ea));
      chk($sformatf("tbl%0d_wd", i), wd, tbl[i].ew);
      chk($sformatf("tbl%0d_busy", i), busy_mask, tbl[i].eb);
      chk($sformatf("tbl%0d_ready", i), 32'(m_ready), 32'h1);
    end
    for (int k = 0; k < 12; k++) begin
      drive(1'b1, 5'd20, 32'(k), k < 4, 5'(10 + k), 32'h100 + 32'(k));
      @(negedge clk);
      chk($sformatf("starve%0d_stall", k), 32'(p_stall), 32'(k == 9));
      chk($sformatf("starve%0d_wr", k), 32'(wr), 32'h1);
      chk($sformatf("starve%0d_a3", k), 32'(a3), k == 10 ? 32'd10 : 32'd20);
      chk($sformatf("starve%0d_ready", k), 32'(m_ready), 32'(!(k >= 3 && k <= 9)));
    end
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk($sformatf("drain%0d_wr", k), 32'(wr), 32'(k < 3));
      if (k < 3) chk($sformatf("drain%0d_a3", k), 32'(a3), 32'd11 + 32'(k));
    end
    chk("drain_busy", busy_mask, 32'h0);
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd1, 32'h55, 1'b1, 5'(4 + k), 32'h66);
      @(negedge clk);
    end
    chk("pre_rst_wr", 32'(wr), 32'h1);
    chk("pre_rst_busy", busy_mask, 32'h70);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_wr", 32'(wr), 32'h0);
    chk("async_rst_busy", busy_mask, 32'h0);
    chk("async_rst_ready", 32'(m_ready), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("post_rst%0d_wr", k), 32'(wr), 32'h0);
      chk($sformatf("post_rst%0d_busy", k), busy_mask, 32'h0);
    end
    mq.delete(); mwait = 0; mstall = 1'b0; ewr = 1'b0; ea3 = '0; ewd = '0; epc = '0;
    for (int c = 0; c < 400; c++) begin
      p_valid = $urandom_range(0, 99) < (c < 200 ? 88 : 50);
      p_a3    = 5'($urandom_range(0, 31));
      p_wd    = $urandom;
      p_pc    = $urandom;
      m_valid = 1'($urandom_range(0, 1));
      m_a3    = 5'($urandom_range(0, 7));
      m_wd    = $urandom;
      m_pc    = $urandom;
      chk($sformatf("rnd%0d_ready", c), 32'(m_ready), 32'(mq.size() < DEPTH));
      model_step();
      @(negedge clk);
      chk($sformatf("rnd%0d_wr", c), 32'(wr), 32'(ewr));
      chk($sformatf("rnd%0d_stall", c), 32'(p_stall), 32'(mstall));
      chk($sformatf("rnd%0d_busy", c), busy_mask, mbusy());
      if (ewr) begin
        chk($sformatf("rnd%0d_a3", c), 32'(a3), 32'(ea3));
        chk($sformatf("rnd%0d_wd", c), wd, ewd);
        chk($sformatf("rnd%0d_pc", c), pc, epc);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
